// File: rtl/reorder_fifo_mp.sv
// Multi-lane in-order FIFO between dispatch and commit: up to PUSH_W pushes and
// POP_W pops per cycle, program order preserved, with flush and occupancy outputs.
module reorder_fifo_mp #(
    parameter int DW     = 64,
    parameter int DP     = 16,
    parameter int PUSH_W = 2,
    parameter int POP_W  = 2
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [PUSH_W-1:0]         dispat_vaild,
    output logic [PUSH_W-1:0]         iOrder_ready,
    input  logic [PUSH_W*DW-1:0]      iOrder_info_push,
    output logic [POP_W-1:0]          iOrder_vaild,
    input  logic [POP_W-1:0]          commit_ready,
    output logic [POP_W*DW-1:0]       iOrder_info_pop,
    input  logic                      flush,
    output logic                      empty,
    output logic                      full,
    output logic [$clog2(DP):0]       count
);

    localparam int AW = $clog2(DP);
    localparam int PW = AW + 1;

    logic [DW-1:0] mem [DP];

    logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PW-1:0] free_cnt;
    logic [PW-1:0] push_cnt;
    logic [PW-1:0] pop_cnt;
    logic [PUSH_W-1:0] push_acc;
    logic [POP_W-1:0]  pop_acc;

    // Occupancy comes from the pointer difference; the extra MSB separates full from empty.
    assign count    = wr_ptr_reg - rd_ptr_reg;
    assign free_cnt = PW'(DP) - count;
    assign empty    = (count == '0);
    assign full     = (count == PW'(DP));

    genvar gi;
    generate
        for (gi = 0; gi < PUSH_W; gi++) begin : g_push_lane
            assign iOrder_ready[gi] = free_cnt > PW'(gi);
        end
        for (gi = 0; gi < POP_W; gi++) begin : g_pop_lane
            logic [AW-1:0] rd_idx;
            assign rd_idx = rd_ptr_reg[AW-1:0] + AW'(gi);
            assign iOrder_vaild[gi] = count > PW'(gi);
            assign iOrder_info_pop[gi*DW +: DW] = iOrder_vaild[gi] ? mem[rd_idx] : '0;
        end
    endgenerate

    assign push_acc = dispat_vaild & iOrder_ready;
    assign pop_acc  = commit_ready & iOrder_vaild;

    // Only the leading run of accepted lanes counts; anything after a gap is ignored.
    always_comb begin
        logic run;
        push_cnt = '0;
        run      = 1'b1;
        for (int i = 0; i < PUSH_W; i++) begin
            if (run && push_acc[i]) push_cnt = push_cnt + PW'(1);
            else                    run      = 1'b0;
        end
    end

    always_comb begin
        logic run;
        pop_cnt = '0;
        run     = 1'b1;
        for (int j = 0; j < POP_W; j++) begin
            if (run && pop_acc[j]) pop_cnt = pop_cnt + PW'(1);
            else                   run     = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_next = wr_ptr_reg + push_cnt;
        rd_ptr_next = rd_ptr_reg + pop_cnt;
        if (flush) begin
            wr_ptr_next = '0;
            rd_ptr_next = '0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
        end
    end

    // Storage is not reset; the low pointer bits wrap so a multi-lane write can straddle DP-1 -> 0.
    always_ff @(posedge CLK) begin
        if (!flush) begin
            for (int i = 0; i < PUSH_W; i++) begin
                if (PW'(i) < push_cnt)
                    mem[wr_ptr_reg[AW-1:0] + AW'(i)] <= iOrder_info_push[i*DW +: DW];
            end
        end
    end

endmodule

// File: tb/tb_reorder_fifo_mp.sv
// Directed bench for reorder_fifo_mp: queue-based reference model compared every
// falling edge, plus hand-computed literal checks for each scenario.
module tb_reorder_fifo_mp;

    localparam int DW = 8, DP = 4, PUSH_W = 2, POP_W = 2;

    logic                 CLK = 1'b0;
    logic                 RST = 1'b1;
    logic [PUSH_W-1:0]    dispat_vaild = '0;
    logic [PUSH_W-1:0]    iOrder_ready;
    logic [PUSH_W*DW-1:0] iOrder_info_push = '0;
    logic [POP_W-1:0]     iOrder_vaild;
    logic [POP_W-1:0]     commit_ready = '0;
    logic [POP_W*DW-1:0]  iOrder_info_pop;
    logic                 flush = 1'b0;
    logic                 empty, full;
    logic [2:0]           count;

    int cmp_count = 0;
    int err_count = 0;

    reorder_fifo_mp #(.DW(DW), .DP(DP), .PUSH_W(PUSH_W), .POP_W(POP_W)) dut (
        .CLK(CLK), .RST(RST),
        .dispat_vaild(dispat_vaild), .iOrder_ready(iOrder_ready),
        .iOrder_info_push(iOrder_info_push),
        .iOrder_vaild(iOrder_vaild), .commit_ready(commit_ready),
        .iOrder_info_pop(iOrder_info_pop),
        .flush(flush), .empty(empty), .full(full), .count(count)
    );

    always #5 CLK = ~CLK;

    // Reference model: plain queue of entries, oldest at the front.
    logic [DW-1:0] q[$];

    always @(posedge CLK or posedge RST) begin
        if (RST || flush) begin
            q.delete();
        end else begin
            int free, np, nc, sz;
            sz = q.size();
            free = DP - sz;
            np = 0;
            while (np < PUSH_W && dispat_vaild[np] && free > np) np++;
            nc = 0;
            while (nc < POP_W && commit_ready[nc] && sz > nc) nc++;
            for (int k = 0; k < nc; k++) void'(q.pop_front());
            for (int k = 0; k < np; k++) q.push_back(iOrder_info_push[k*DW +: DW]);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_count++;
        if (act !== exp) begin
            err_count++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        logic [PUSH_W-1:0]    e_rdy;
        logic [POP_W-1:0]     e_vld;
        logic [POP_W*DW-1:0]  e_pop;
        int sz;
        sz = q.size();
        e_pop = '0;
        for (int i = 0; i < PUSH_W; i++) e_rdy[i] = (DP - sz) > i;
        for (int j = 0; j < POP_W; j++) begin
            e_vld[j] = sz > j;
            if (sz > j) e_pop[j*DW +: DW] = q[j];
        end
        check("model_count", 64'(count), 64'(sz));
        check("model_empty", 64'(empty), 64'(sz == 0));
        check("model_full",  64'(full),  64'(sz == DP));
        check("model_ready", 64'(iOrder_ready), 64'(e_rdy));
        check("model_vaild", 64'(iOrder_vaild), 64'(e_vld));
        check("model_pop",   64'(iOrder_info_pop), 64'(e_pop));
        $display("cycle t=%0t cnt=%0d rdy=%b vld=%b pop=%h", $time, count, iOrder_ready, iOrder_vaild, iOrder_info_pop);
    end

    // Drive one cycle of inputs from a falling edge, then idle the inputs and return at the next falling edge.
    task automatic step(input logic [1:0] dv, input logic [7:0] d1, input logic [7:0] d0,
                        input logic [1:0] cr, input logic fl);
        dispat_vaild = dv;
        iOrder_info_push = {d1, d0};
        commit_ready = cr;
        flush = fl;
        @(posedge CLK);
        #1;
        dispat_vaild = '0;
        iOrder_info_push = '0;
        commit_ready = '0;
        flush = 1'b0;
        @(negedge CLK);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_empty"}, 64'(empty), 64'd1);
        check({tag, "_full"},  64'(full),  64'd0);
        check({tag, "_count"}, 64'(count), 64'd0);
        check({tag, "_ready"}, 64'(iOrder_ready), 64'b11);
        check({tag, "_vaild"}, 64'(iOrder_vaild), 64'b00);
        check({tag, "_pop"},   64'(iOrder_info_pop), 64'h0000);
    endtask

    initial begin
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check_reset_vals("reset");

        // Dual push then dual pop
        step(2'b11, 8'hA1, 8'hA0, 2'b00, 1'b0);
        check("dual_vaild", 64'(iOrder_vaild), 64'b11);
        check("dual_pop",   64'(iOrder_info_pop), 64'hA1A0);
        step(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
        check("dual_empty", 64'(empty), 64'd1);

        // Fill and wrap across index 3 -> 0
        step(2'b11, 8'hB1, 8'hB0, 2'b00, 1'b0);
        step(2'b11, 8'hB3, 8'hB2, 2'b00, 1'b0);
        check("fill_full",  64'(full), 64'd1);
        check("fill_ready", 64'(iOrder_ready), 64'b00);
        step(2'b00, 8'h00, 8'h00, 2'b01, 1'b0);
        check("pop1_ready", 64'(iOrder_ready), 64'b01);
        check("pop1_pop",   64'(iOrder_info_pop), 64'hB2B1);
        step(2'b11, 8'hC1, 8'hC0, 2'b00, 1'b0);
        check("near_count", 64'(count), 64'd4);
        step(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
        check("drain1_pop", 64'(iOrder_info_pop), 64'hC0B3);
        step(2'b00, 8'h00, 8'h00, 2'b11, 1'b0);
        check("drain2_empty", 64'(empty), 64'd1);

        // Gap rule
        step(2'b10, 8'hEE, 8'hDD, 2'b00, 1'b0);
        check("gap_push_count", 64'(count), 64'd0);
        step(2'b11, 8'hD1, 8'hD0, 2'b00, 1'b0);
        step(2'b00, 8'h00, 8'h00, 2'b10, 1'b0);
        check("gap_pop_count", 64'(count), 64'd2);
        check("gap_pop_data",  64'(iOrder_info_pop), 64'hD1D0);

        // Simultaneous push and pop at count 2
        step(2'b11, 8'hE1, 8'hE0, 2'b11, 1'b0);
        check("simul_count", 64'(count), 64'd2);
        check("simul_pop",   64'(iOrder_info_pop), 64'hE1E0);

        // Flush overrides a same-cycle push
        step(2'b01, 8'h00, 8'hF0, 2'b00, 1'b0);
        check("pre_flush_count", 64'(count), 64'd3);
        step(2'b11, 8'hF2, 8'hF1, 2'b00, 1'b1);
        check("flush_count", 64'(count), 64'd0);
        check("flush_empty", 64'(empty), 64'd1);

        // Asynchronous reset between edges
        step(2'b11, 8'h91, 8'h90, 2'b00, 1'b0);
        check("pre_rst_count", 64'(count), 64'd2);
        @(posedge CLK);
        #2;
        RST = 1'b1;
        #1;
        check_reset_vals("async_rst");
        @(negedge CLK);
        RST = 1'b0;
        step(2'b11, 8'h81, 8'h80, 2'b00, 1'b0);
        check("post_rst_pop", 64'(iOrder_info_pop), 64'h8180);

        @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
        $finish;
    end

endmodule
